// File: rtl/cdc_dev_pkg.sv
// cdc_dev_pkg: shared constants and types for the USB CDC device-side blocks.
package cdc_dev_pkg;
    localparam int BYTE_W = 8;
    localparam int FRAME_TICK_BIT = 0;
    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin pick of the first valid entry after last.
module rr_priority_picker #(
    parameter int N = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] idx,
    output logic          any_valid
);
    // Walk offsets from farthest to nearest so the nearest valid one after last wins.
    always_comb begin
        idx = '0;
        for (int o = N; o >= 1; o--)
            if (valid[(int'(last) + o) % N]) idx = IW'((int'(last) + o) % N);
        any_valid = |valid;
        pick = any_valid ? (N'(1) << idx) : '0;
    end
endmodule

// File: rtl/cdc_in_arbiter.sv
// cdc_in_arbiter: round-robin sharing of the USB CDC IN byte channel between requesters,
// with bounded bursts, frame-based fairness rotation and flushing while unconfigured.
module cdc_in_arbiter
    import cdc_dev_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int MAX_BURST = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ*BYTE_W-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [BYTE_W-1:0]         in_data_o,
    output logic                      in_valid_o,
    input  logic                      in_ready_i,
    input  logic [10:0]               frame_i,
    input  logic                      usb_configured_i,
    output logic [NUM_REQ-1:0]        grant_o
);
    localparam int IW = $clog2(NUM_REQ);

    arb_state_t        state, state_nxt;
    logic [IW-1:0]     last_grant, pick_idx;
    logic [NUM_REQ-1:0] pick_oh;
    logic              any_valid;
    logic [7:0]        burst_cnt;
    logic              frame_q, frame_tick;
    logic              space, xfer, release_g, others_valid;
    logic              frame_unused;

    assign frame_unused = |frame_i;

    rr_priority_picker #(.N(NUM_REQ)) u_pick (
        .valid     (req_valid_i),
        .last      (last_grant),
        .pick      (pick_oh),
        .idx       (pick_idx),
        .any_valid (any_valid)
    );

    // While granted, last_grant is the index of the current grantee.
    assign space        = ~in_valid_o | in_ready_i;
    assign req_ready_o  = usb_configured_i ? (grant_o & {NUM_REQ{space}}) : '1;
    assign xfer         = usb_configured_i & (state == ARB_GRANT) & req_valid_i[last_grant] & space;
    assign others_valid = |(req_valid_i & ~grant_o);
    assign release_g    = (xfer && burst_cnt == 8'(MAX_BURST - 1))
                        || (!req_valid_i[last_grant] && space)
                        || (frame_tick && others_valid);

    always_comb begin
        state_nxt = !usb_configured_i  ? ARB_IDLE :
                    state == ARB_IDLE  ? (any_valid ? ARB_GRANT : ARB_IDLE) :
                    release_g          ? ARB_IDLE : ARB_GRANT;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= ARB_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant <= IW'(NUM_REQ - 1);
            grant_o    <= '0;
            burst_cnt  <= '0;
            frame_q    <= 1'b0;
            frame_tick <= 1'b0;
            in_data_o  <= '0;
            in_valid_o <= 1'b0;
        end else begin
            frame_q    <= frame_i[FRAME_TICK_BIT];
            frame_tick <= frame_i[FRAME_TICK_BIT] ^ frame_q;
            grant_o    <= state_nxt == ARB_GRANT ? (state == ARB_IDLE ? pick_oh : grant_o) : '0;
            if (state == ARB_IDLE && state_nxt == ARB_GRANT) last_grant <= pick_idx;
            burst_cnt  <= (state == ARB_GRANT && state_nxt == ARB_GRANT) ? burst_cnt + 8'(xfer) : 8'd0;
            in_valid_o <= usb_configured_i & (xfer | (in_valid_o & ~in_ready_i));
            if (xfer) in_data_o <= req_data_i[last_grant*BYTE_W +: BYTE_W];
        end
    end
endmodule

// File: tb/tb_cdc_in_arbiter.sv
// tb_cdc_in_arbiter: scoreboard bench; expected byte order comes from a burst-level round-robin model.
module tb_cdc_in_arbiter;
    localparam int MB = 8;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] req_data_i = '0;
    logic [1:0]  req_valid_i = '0;
    logic [1:0]  req_ready_o;
    logic [7:0]  in_data_o;
    logic        in_valid_o;
    logic        in_ready_i = 1'b1;
    logic [10:0] frame_i = '0;
    logic        usb_configured_i = 1'b1;
    logic [1:0]  grant_o;

    int   passed = 0, total = 0;
    bit   sb_en = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] srcq[2][$];
    logic [7:0] gen[2][64];
    int   model_last;

    always #5 clk = ~clk;

    cdc_in_arbiter #(.NUM_REQ(2), .MAX_BURST(MB)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .req_data_i       (req_data_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .in_data_o        (in_data_o),
        .in_valid_o       (in_valid_o),
        .in_ready_i       (in_ready_i),
        .frame_i          (frame_i),
        .usb_configured_i (usb_configured_i),
        .grant_o          (grant_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [1:0] oh(input int r);
        return 2'(1 << r);
    endfunction

    task automatic drive();
        for (int r = 0; r < 2; r++) begin
            req_valid_i[r] = srcq[r].size() > 0;
            req_data_i[8*r +: 8] = srcq[r].size() > 0 ? srcq[r][0] : 8'h00;
        end
    endtask

    task automatic gen_bytes(input int r, input int n);
        for (int i = 0; i < n; i++) begin
            gen[r][i] = 8'($urandom);
            srcq[r].push_back(gen[r][i]);
        end
    endtask

    // One clock: requester byte is consumed on valid & ready at the edge.
    task automatic cyc();
        logic [1:0] c;
        logic [7:0] d;
        @(negedge clk);
        c = req_valid_i & req_ready_o;
        @(posedge clk);
        #1;
        for (int r = 0; r < 2; r++)
            if (c[r] && srcq[r].size() > 0) d = srcq[r].pop_front();
        drive();
    endtask

    always @(negedge clk) begin
        if (!rst_i) begin
            chk("grant_onehot0", 32'($onehot0(grant_o)), 32'd1);
            if (usb_configured_i) chk("ready_onehot0", 32'($onehot0(req_ready_o)), 32'd1);
            if (sb_en && in_valid_o && in_ready_i) begin
                chk("sb_unexpected_byte", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("sb_byte", 32'(in_data_o), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int k, a, b;
        drive();
        #1;
        chk("rst_in_valid", 32'(in_valid_o), 32'd0);
        chk("rst_in_data", 32'(in_data_o), 32'd0);
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Single requester, three bytes: grant at cycle 1, output on cycles 2..4.
        model_last = 1;
        foreach (gen[0][i]) gen[0][i] = 8'h00;
        srcq[0].push_back(8'h41); srcq[0].push_back(8'h42); srcq[0].push_back(8'h43);
        exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
        sb_en = 1'b1;
        drive();
        cyc(); chk("t1_grant", 32'(grant_o), 32'(oh((model_last + 1) % 2)));
        cyc(); chk("t1_valid", 32'(in_valid_o), 32'd1); chk("t1_byte0", 32'(in_data_o), 32'h41);
        cyc(); chk("t1_byte1", 32'(in_data_o), 32'h42);
        cyc(); chk("t1_byte2", 32'(in_data_o), 32'h43);
        cyc(); chk("t1_release", 32'(grant_o), 32'd0); chk("t1_idle_valid", 32'(in_valid_o), 32'd0);
        model_last = 0;

        // Both requesters saturated: alternating bursts of MB bytes, then random backpressure.
        a = (model_last + 1) % 2; b = 1 - a;
        gen_bytes(0, 5 * MB); gen_bytes(1, 5 * MB);
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < MB; j++)
                exp_q.push_back(gen[(i % 2 == 0) ? a : b][(i / 2) * MB + j]);
        drive();
        k = 0;
        while (exp_q.size() > 0 && k < 3000) begin
            cyc(); k++;
            if (k == 1) chk("t2_first_grant", 32'(grant_o), 32'(oh(a)));
            if (k == MB + 1) chk("t2_bubble", 32'(grant_o), 32'd0);
            if (k == MB + 2) chk("t2_rotate", 32'(grant_o), 32'(oh(b)));
            if (k == MB + 4) in_ready_i = 1'b0;
            if (k >= MB + 4 && k <= MB + 8) begin
                #1;
                chk("t2_hold_valid", 32'(in_valid_o), 32'd1);
                chk("t2_hold_data", 32'(in_data_o), 32'(gen[b][1]));
                chk("t2_hold_ready", 32'(req_ready_o), 32'd0);
            end
            if (k > MB + 8) in_ready_i = ($urandom_range(0, 3) != 0);
        end
        chk("t2_drained", 32'(exp_q.size()), 32'd0);
        in_ready_i = 1'b1;
        repeat (3) cyc();
        model_last = b;

        // Frame tick on the third byte of a burst while the other requester waits.
        a = (model_last + 1) % 2; b = 1 - a;
        gen_bytes(a, 8); gen_bytes(b, 4);
        for (int j = 0; j < 3; j++) exp_q.push_back(gen[a][j]);
        for (int j = 0; j < 4; j++) exp_q.push_back(gen[b][j]);
        for (int j = 3; j < 8; j++) exp_q.push_back(gen[a][j]);
        drive();
        k = 0;
        while (exp_q.size() > 0 && k < 200) begin
            cyc(); k++;
            if (k == 2) frame_i = frame_i + 11'd1;
            if (k == 4) chk("t4_tick_release", 32'(grant_o), 32'd0);
            if (k == 5) chk("t4_tick_rotate", 32'(grant_o), 32'(oh(b)));
        end
        chk("t4_drained", 32'(exp_q.size()), 32'd0);
        repeat (3) cyc();
        model_last = a;

        // Deconfigure with a pending output byte, then reconfigure.
        a = (model_last + 1) % 2; b = 1 - a;
        sb_en = 1'b0;
        gen_bytes(a, 6); gen_bytes(b, 3);
        drive();
        cyc(); chk("t5_grant", 32'(grant_o), 32'(oh(a)));
        cyc(); chk("t5_pending", 32'(in_valid_o), 32'd1);
        in_ready_i = 1'b0; usb_configured_i = 1'b0;
        #1; chk("t5_flush_ready_comb", 32'(req_ready_o), 32'd3);
        cyc();
        chk("t5_drop_valid", 32'(in_valid_o), 32'd0);
        chk("t5_drop_grant", 32'(grant_o), 32'd0);
        chk("t5_flush_ready", 32'(req_ready_o), 32'd3);
        usb_configured_i = 1'b1; in_ready_i = 1'b1;
        cyc(); chk("t5_regrant_next", 32'(grant_o), 32'(oh(b)));
        k = 0;
        while ((srcq[0].size() > 0 || srcq[1].size() > 0) && k < 200) begin
            cyc(); k++;
        end
        chk("t5_drained", 32'(srcq[0].size() + srcq[1].size()), 32'd0);
        repeat (3) cyc();

        // Asynchronous reset mid-transfer, then requester 0 must win first.
        gen_bytes(0, 20);
        drive();
        repeat (3) cyc();
        chk("t6_pre_valid", 32'(in_valid_o), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("t6_async_valid", 32'(in_valid_o), 32'd0);
        chk("t6_async_data", 32'(in_data_o), 32'd0);
        chk("t6_async_grant", 32'(grant_o), 32'd0);
        srcq[0].delete(); srcq[1].delete();
        drive();
        frame_i = '0;
        repeat (2) cyc();
        rst_i = 1'b0;
        gen_bytes(1, 3); gen_bytes(0, 3);
        for (int j = 0; j < 3; j++) exp_q.push_back(gen[0][j]);
        for (int j = 0; j < 3; j++) exp_q.push_back(gen[1][j]);
        sb_en = 1'b1;
        drive();
        cyc(); chk("t6_first_after_reset", 32'(grant_o), 32'd1);
        k = 0;
        while (exp_q.size() > 0 && k < 200) begin
            cyc(); k++;
        end
        chk("t6_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
